down_counter_timer: RTL and testbench

//  Loadable, prescaled down-counter/timer with one-shot and auto-reload modes.
//  It complements the free-running up-counter: software loads a value, starts it, and

---
 rtl/down_counter_timer.sv | 112 +++++++++++
 tb/tb_down_counter_timer.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/down_counter_timer.sv
// Loadable, prescaled down-counter/timer with one-shot and auto-reload modes.
// Emits a one-cycle terminal-count pulse when the count reaches zero.
module down_counter_timer #(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned PRESCALE_W = 8
) (
  input  logic                  i_clock,
  input  logic                  i_rst,
  input  logic                  i_load_valid,
  output logic                  o_load_ready,
  input  logic [WIDTH-1:0]      i_load_value,
  input  logic [PRESCALE_W-1:0] i_prescale,
  input  logic                  i_auto_reload,
  input  logic                  i_start,
  input  logic                  i_stop,
  output logic [WIDTH-1:0]      o_count,
  output logic                  o_busy,
  output logic                  o_tc_pulse,
  output logic [1:0]            o_state
);

  typedef enum logic [1:0] {
    StIdle  = 2'b00,
    StArmed = 2'b01,
    StRun   = 2'b10,
    StPause = 2'b11
  } state_e;

  state_e                r_state;
  logic [WIDTH-1:0]      r_count;
  logic [WIDTH-1:0]      r_reload;
  logic [PRESCALE_W-1:0] r_prescale;
  logic [PRESCALE_W-1:0] r_pre_cnt;
  logic                  r_autorl;
  logic                  r_tc;

  logic w_load;
  logic w_go;
  logic w_tick;

  assign o_load_ready = (r_state != StRun);
  assign w_load       = i_load_valid && o_load_ready;
  assign w_go         = i_start && !i_stop;
  assign w_tick       = (r_pre_cnt == r_prescale) && !i_stop;

  always_ff @(posedge i_clock or posedge i_rst) begin
    if (i_rst) begin
      r_state    <= StIdle;
      r_count    <= '0;
      r_reload   <= '0;
      r_prescale <= '0;
      r_pre_cnt  <= '0;
      r_autorl   <= 1'b0;
      r_tc       <= 1'b0;
    end else begin
      r_tc <= 1'b0;
      if (w_load) begin
        r_count    <= i_load_value;
        r_reload   <= i_load_value;
        r_prescale <= i_prescale;
        r_autorl   <= i_auto_reload;
        r_pre_cnt  <= '0;
        r_state    <= StArmed;
      end else begin
        case (r_state)
          StArmed: begin
            if (w_go) begin
              if (r_count != '0) begin
                r_state   <= StRun;
                r_pre_cnt <= '0;
              end else begin
                // Zero load expires at once; never reloads even in periodic mode.
                r_state <= StIdle;
                r_tc    <= 1'b1;
              end
            end
          end
          StRun: begin
            if (i_stop) begin
              r_state <= StPause;
            end else if (w_tick) begin
              r_pre_cnt <= '0;
              if (r_count > WIDTH'(1)) begin
                r_count <= r_count - WIDTH'(1);
              end else if (r_count == WIDTH'(1)) begin
                r_tc <= 1'b1;
                if (r_autorl) begin
                  r_count <= r_reload;
                end else begin
                  r_count <= '0;
                  r_state <= StIdle;
                end
              end
            end else begin
              r_pre_cnt <= r_pre_cnt + PRESCALE_W'(1);
            end
          end
          StPause: begin
            if (w_go) r_state <= StRun;
          end
          default: ;
        endcase
      end
    end
  end

  assign o_count    = r_count;
  assign o_busy     = (r_state == StRun);
  assign o_tc_pulse = r_tc;
  assign o_state    = r_state;

endmodule

// File: tb/tb_down_counter_timer.sv
// Scoreboard bench for down_counter_timer: stimulus queues the expected post-edge
// state each cycle, a monitor pops and compares after every rising edge.
module tb_down_counter_timer;

  localparam int unsigned WIDTH      = 32;
  localparam int unsigned PRESCALE_W = 8;
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ARMED = 2'd1;
  localparam logic [1:0] RUN   = 2'd2;
  localparam logic [1:0] PAUSE = 2'd3;

  logic                  clk = 1'b0;
  logic                  rst = 1'b0;
  logic                  load_valid = 1'b0;
  logic                  load_ready;
  logic [WIDTH-1:0]      load_value = '0;
  logic [PRESCALE_W-1:0] prescale = '0;
  logic                  auto_reload = 1'b0;
  logic                  start = 1'b0;
  logic                  stop = 1'b0;
  logic [WIDTH-1:0]      count;
  logic                  busy;
  logic                  tc_pulse;
  logic [1:0]            state;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string            name;
    logic [WIDTH-1:0] cnt;
    logic [1:0]       st;
    logic             tc;
  } exp_t;

  exp_t sb_q[$];

  down_counter_timer #(
    .WIDTH     (WIDTH),
    .PRESCALE_W(PRESCALE_W)
  ) dut (
    .i_clock      (clk),
    .i_rst        (rst),
    .i_load_valid (load_valid),
    .o_load_ready (load_ready),
    .i_load_value (load_value),
    .i_prescale   (prescale),
    .i_auto_reload(auto_reload),
    .i_start      (start),
    .i_stop       (stop),
    .o_count      (count),
    .o_busy       (busy),
    .o_tc_pulse   (tc_pulse),
    .o_state      (state)
  );

  always #5 clk = ~clk;

  task automatic cmp(input exp_t e);
    logic exp_busy;
    logic exp_ready;
    exp_busy  = (e.st == RUN);
    exp_ready = (e.st != RUN);
    checks++;
    if (count !== e.cnt || state !== e.st || tc_pulse !== e.tc ||
        busy !== exp_busy || load_ready !== exp_ready) begin
      errors++;
      $display("FAIL %s: got count=%0d state=%0d tc=%b busy=%b ready=%b, want count=%0d state=%0d tc=%b busy=%b ready=%b",
               e.name, count, state, tc_pulse, busy, load_ready,
               e.cnt, e.st, e.tc, exp_busy, exp_ready);
    end
  endtask

  // Monitor: one expected record per edge at which stimulus queued one.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() > 0) cmp(sb_q.pop_front());
    end
  end

  task automatic step(input logic lv, input logic [WIDTH-1:0] val,
                      input logic [PRESCALE_W-1:0] psc, input logic ar,
                      input logic st, input logic sp, input string nm,
                      input logic [WIDTH-1:0] ec, input logic [1:0] es, input logic et);
    exp_t e;
    @(negedge clk);
    load_valid  = lv;
    load_value  = val;
    prescale    = psc;
    auto_reload = ar;
    start       = st;
    stop        = sp;
    e.name = nm;
    e.cnt  = ec;
    e.st   = es;
    e.tc   = et;
    sb_q.push_back(e);
  endtask

  task automatic idle(input logic st, input logic sp, input string nm,
                      input logic [WIDTH-1:0] ec, input logic [1:0] es, input logic et);
    step(1'b0, '0, '0, 1'b0, st, sp, nm, ec, es, et);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at time %0t, required finish earlier", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t r;
    r.name = "reset";
    r.cnt  = '0;
    r.st   = IDLE;
    r.tc   = 1'b0;
    #2 rst = 1'b1;
    #1 cmp(r);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // 1: prescale 0, one-shot 3
    step(1'b1, 3, 0, 1'b0, 1'b0, 1'b0, "t1_load", 3, ARMED, 1'b0);
    idle(1'b1, 1'b0, "t1_run", 3, RUN, 1'b0);
    idle(1'b0, 1'b0, "t1_c2", 2, RUN, 1'b0);
    idle(1'b0, 1'b0, "t1_c1", 1, RUN, 1'b0);
    idle(1'b0, 1'b0, "t1_tc", 0, IDLE, 1'b1);
    idle(1'b1, 1'b0, "t1_idle_start_ignored", 0, IDLE, 1'b0);

    // 2: prescale 1, auto-reload 2
    step(1'b1, 2, 1, 1'b1, 1'b0, 1'b0, "t2_load", 2, ARMED, 1'b0);
    idle(1'b1, 1'b0, "t2_run", 2, RUN, 1'b0);
    idle(1'b0, 1'b0, "t2_a", 2, RUN, 1'b0);
    idle(1'b0, 1'b0, "t2_b", 1, RUN, 1'b0);
    idle(1'b0, 1'b0, "t2_c", 1, RUN, 1'b0);
    idle(1'b0, 1'b0, "t2_tc1", 2, RUN, 1'b1);
    idle(1'b0, 1'b0, "t2_d", 2, RUN, 1'b0);
    idle(1'b0, 1'b0, "t2_e", 1, RUN, 1'b0);
    idle(1'b0, 1'b0, "t2_f", 1, RUN, 1'b0);
    idle(1'b0, 1'b0, "t2_tc2", 2, RUN, 1'b1);
    idle(1'b0, 1'b1, "t2_stop", 2, PAUSE, 1'b0);

    // 3: load 5 from PAUSE, pause for 3 cycles after two decrements
    step(1'b1, 5, 0, 1'b0, 1'b0, 1'b0, "t3_load", 5, ARMED, 1'b0);
    idle(1'b1, 1'b0, "t3_run", 5, RUN, 1'b0);
    idle(1'b0, 1'b0, "t3_c4", 4, RUN, 1'b0);
    idle(1'b0, 1'b0, "t3_c3", 3, RUN, 1'b0);
    idle(1'b0, 1'b1, "t3_p1", 3, PAUSE, 1'b0);
    idle(1'b0, 1'b1, "t3_p2", 3, PAUSE, 1'b0);
    idle(1'b0, 1'b1, "t3_p3", 3, PAUSE, 1'b0);
    idle(1'b1, 1'b0, "t3_resume", 3, RUN, 1'b0);
    idle(1'b0, 1'b0, "t3_c2", 2, RUN, 1'b0);
    idle(1'b0, 1'b0, "t3_c1", 1, RUN, 1'b0);
    idle(1'b0, 1'b0, "t3_tc", 0, IDLE, 1'b1);
    idle(1'b0, 1'b0, "t3_after", 0, IDLE, 1'b0);

    // Prescaler phase is held across a pause (prescale 2)
    step(1'b1, 3, 2, 1'b0, 1'b0, 1'b0, "tp_load", 3, ARMED, 1'b0);
    idle(1'b1, 1'b0, "tp_run", 3, RUN, 1'b0);
    idle(1'b0, 1'b0, "tp_pre1", 3, RUN, 1'b0);
    idle(1'b0, 1'b1, "tp_pause", 3, PAUSE, 1'b0);
    idle(1'b1, 1'b0, "tp_resume", 3, RUN, 1'b0);
    idle(1'b0, 1'b0, "tp_pre2", 3, RUN, 1'b0);
    idle(1'b0, 1'b0, "tp_c2", 2, RUN, 1'b0);
    idle(1'b0, 1'b0, "tp_c2a", 2, RUN, 1'b0);
    idle(1'b0, 1'b0, "tp_c2b", 2, RUN, 1'b0);
    idle(1'b0, 1'b0, "tp_c1", 1, RUN, 1'b0);
    idle(1'b0, 1'b0, "tp_c1a", 1, RUN, 1'b0);
    idle(1'b0, 1'b0, "tp_c1b", 1, RUN, 1'b0);
    idle(1'b0, 1'b0, "tp_tc", 0, IDLE, 1'b1);

    // 4: zero load expires immediately, no reload even in periodic mode
    step(1'b1, 0, 0, 1'b1, 1'b0, 1'b0, "t4_load0", 0, ARMED, 1'b0);
    idle(1'b1, 1'b0, "t4_tc0", 0, IDLE, 1'b1);
    idle(1'b0, 1'b0, "t4_idle", 0, IDLE, 1'b0);
    step(1'b1, 4, 0, 1'b0, 1'b1, 1'b1, "t4_load_ss", 4, ARMED, 1'b0);
    idle(1'b1, 1'b1, "t4_hold_armed", 4, ARMED, 1'b0);

    // 6: load ignored during RUN; load beats start in PAUSE
    idle(1'b1, 1'b0, "t6_run", 4, RUN, 1'b0);
    step(1'b1, 9, 0, 1'b0, 1'b0, 1'b0, "t6_load_in_run", 3, RUN, 1'b0);
    idle(1'b0, 1'b0, "t6_c2", 2, RUN, 1'b0);
    idle(1'b0, 1'b1, "t6_pause", 2, PAUSE, 1'b0);
    step(1'b1, 6, 0, 1'b0, 1'b1, 1'b0, "t6_load_start", 6, ARMED, 1'b0);
    idle(1'b1, 1'b0, "t6_run6", 6, RUN, 1'b0);

    // 5: asynchronous reset mid-run
    idle(1'b0, 1'b0, "t5_c5", 5, RUN, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    r.name = "t5_async_rst";
    cmp(r);
    @(posedge clk);
    #1;
    r.name = "t5_rst_held";
    cmp(r);
    @(negedge clk);
    rst = 1'b0;
    idle(1'b0, 1'b0, "t5_after", 0, IDLE, 1'b0);
    idle(1'b1, 1'b0, "t5_idle_start", 0, IDLE, 1'b0);

    @(negedge clk);
    @(negedge clk);
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending entries, want 0", sb_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
